// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its neighbours.
package if_stage_pkg;

    localparam int PFS_TO_FS_BUS_WD = 65;
    localparam int FS_TO_DS_BUS_WD  = 70;
    localparam int DISCARD_CNT_W    = 2;

    localparam logic [4:0] EX_ADEL = 5'h04;

    typedef struct packed {
        logic        inst_ok;
        logic [31:0] inst;
        logic [31:0] pc;
    } pfs_to_fs_bus_t;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_bus_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fs_discard_ctr.sv
// Saturating add/sub counter of inst_sram responses that must be dropped after a flush.
module fs_discard_ctr
    import if_stage_pkg::*;
#(
    parameter int W = DISCARD_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W+1:0] CNT_MAX = {2'b00, {W{1'b1}}};
    localparam logic [W+1:0] CNT_ONE = {{(W+1){1'b0}}, 1'b1};

    logic [W+1:0] sum_s;
    logic [W+1:0] net_s;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: add increments, subtract one dropped response, clamp both ends.
    always_comb begin
        sum_s = {2'b00, cnt_q} + {{W{1'b0}}, inc};
        net_s = sum_s;
        ovf   = 1'b0;
        cnt_d = cnt_q;
        if (dec && (sum_s != {(W+2){1'b0}})) begin
            net_s = sum_s - CNT_ONE;
        end else begin
            net_s = sum_s;
        end
        if (net_s > CNT_MAX) begin
            cnt_d = CNT_MAX[W-1:0];
            ovf   = 1'b1;
        end else begin
            cnt_d = net_s[W-1:0];
            ovf   = 1'b0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

    fs_discard_ctr_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .ovf   (ovf)
    );

endmodule

// File: rtl/fs_discard_ctr_chk.sv
// Property checker for the stale-response discard counter.
module fs_discard_ctr_chk (
    input logic clk,
    input logic reset,
    input logic ovf
);

    // The counter must never be asked to count past its saturation value.
    assert property (@(posedge clk) disable iff (reset) !ovf);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds one PC, waits for its inst_sram word, flags AdEL,
// and drops responses left over from flushed fetches.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pfs_to_fs_valid,
    input  logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
    output logic                        fs_allowin,
    output logic                        fs_valid,
    output logic                        fs_inst_buff_full,
    input  logic [31:0]                 inst_sram_rdata,
    input  logic                        inst_sram_data_ok,
    input  logic                        inst_sram_data_waiting,
    input  logic                        ds_allowin,
    output logic                        fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0]  fs_to_ds_bus,
    input  logic                        ws_ex,
    input  logic                        ws_eret
);

    pfs_to_fs_bus_t pfs_bus_s;
    fs_to_ds_bus_t  ds_bus_s;

    logic        fs_valid_d,     fs_valid_q;
    logic [31:0] fs_pc_d,        fs_pc_q;
    logic [31:0] inst_buff_d,    inst_buff_q;
    logic        buff_valid_d,   buff_valid_q;

    logic [DISCARD_CNT_W-1:0] discard_cnt_s;
    logic                     discard_busy_s;
    logic                     flush_s;
    logic                     data_ok_for_fs_s;
    logic                     fs_ready_go_s;
    logic                     fs_allowin_s;
    logic [1:0]               discard_inc_s;
    logic                     discard_dec_s;
    logic                     discard_ovf_s;

    assign pfs_bus_s        = pfs_bus_t_cast(pfs_to_fs_bus);
    assign flush_s          = ws_ex | ws_eret;
    assign discard_busy_s   = (discard_cnt_s != {DISCARD_CNT_W{1'b0}});
    assign fs_ready_go_s    = buff_valid_q;
    assign fs_allowin_s     = !fs_valid_q || (fs_ready_go_s && ds_allowin);
    assign data_ok_for_fs_s = inst_sram_data_ok && fs_valid_q && !buff_valid_q && !discard_busy_s;

    // A flush orphans IF's own outstanding response and any response pre-IF is still owed.
    always_comb begin
        discard_inc_s = 2'b00;
        discard_dec_s = inst_sram_data_ok && discard_busy_s;
        if (flush_s) begin
            discard_inc_s = {1'b0, (fs_valid_q && !buff_valid_q && !data_ok_for_fs_s)}
                          + {1'b0, inst_sram_data_waiting};
        end else begin
            discard_inc_s = 2'b00;
        end
    end

    // Slot and instruction-buffer next state; flush outranks accept and capture.
    always_comb begin
        fs_valid_d   = fs_valid_q;
        fs_pc_d      = fs_pc_q;
        inst_buff_d  = inst_buff_q;
        buff_valid_d = buff_valid_q;
        if (flush_s) begin
            fs_valid_d   = 1'b0;
            buff_valid_d = 1'b0;
        end else if (fs_allowin_s) begin
            fs_valid_d = pfs_to_fs_valid;
            if (pfs_to_fs_valid) begin
                fs_pc_d = pfs_bus_s.pc;
                if (pfs_bus_s.inst_ok) begin
                    inst_buff_d  = pfs_bus_s.inst;
                    buff_valid_d = 1'b1;
                end else begin
                    buff_valid_d = 1'b0;
                end
            end else begin
                buff_valid_d = 1'b0;
            end
        end else if (data_ok_for_fs_s) begin
            inst_buff_d  = inst_sram_rdata;
            buff_valid_d = 1'b1;
        end else begin
            buff_valid_d = buff_valid_q;
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q   <= 1'b0;
            fs_pc_q      <= 32'h0000_0000;
            inst_buff_q  <= 32'h0000_0000;
            buff_valid_q <= 1'b0;
        end else begin
            fs_valid_q   <= fs_valid_d;
            fs_pc_q      <= fs_pc_d;
            inst_buff_q  <= inst_buff_d;
            buff_valid_q <= buff_valid_d;
        end
    end

    fs_discard_ctr #(
        .W (DISCARD_CNT_W)
    ) u_discard_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (discard_inc_s),
        .dec   (discard_dec_s),
        .cnt   (discard_cnt_s),
        .ovf   (discard_ovf_s)
    );

    // A misaligned PC still waits for its word, but the word itself is hidden from decode.
    always_comb begin
        ds_bus_s.pc = fs_pc_q;
        if (pc_misaligned(fs_pc_q)) begin
            ds_bus_s.ex     = 1'b1;
            ds_bus_s.excode = EX_ADEL;
            ds_bus_s.inst   = 32'h0000_0000;
        end else begin
            ds_bus_s.ex     = 1'b0;
            ds_bus_s.excode = 5'h00;
            ds_bus_s.inst   = inst_buff_q;
        end
    end

    assign fs_allowin        = fs_allowin_s;
    assign fs_valid          = fs_valid_q;
    assign fs_inst_buff_full = !fs_valid_q || buff_valid_q || discard_busy_s;
    assign fs_to_ds_valid    = fs_valid_q && fs_ready_go_s && !flush_s;
    assign fs_to_ds_bus      = ds_bus_s;

    function automatic pfs_to_fs_bus_t pfs_bus_t_cast(input logic [PFS_TO_FS_BUS_WD-1:0] raw);
        return pfs_to_fs_bus_t'(raw);
    endfunction

endmodule
